// File: rtl/ioctl_loader.sv
// ioctl_loader: streams an hps_io ioctl download into one of NREG byte-wide
// load regions and reports per-load status.
//
// Parameters
//   AW         target byte address width (region capacity 2^AW)
//   NREG       number of load regions (1..8)
//   IDX_BASE   ioctl_index of region 0; region r uses IDX_BASE+r
//   HDR_BYTES  leading file bytes discarded before storing
//
// Ports
//   clk_sys, reset                  clock, async active-high reset
//   ioctl_download/index/wr/addr/dout  hps_io download interface
//   mem_addr, mem_data, mem_we      registered write port, mem_we one-hot per region
//   busy                            high in LOAD or IGNORE
//   done                            one-cycle pulse when a region load completes
//   last_region, size, size_mask,
//   checksum, overflow              status of the most recent completed load
//
// Handshake: a byte is taken only when ioctl_wr=1 and ioctl_download=1 in the
// same cycle while in LOAD; the resulting memory write appears on the next
// cycle as a single-cycle mem_we pulse. There is no back-pressure.
module ioctl_loader #(
    parameter int AW        = 15,
    parameter int NREG      = 2,
    parameter int IDX_BASE  = 1,
    parameter int HDR_BYTES = 0
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ioctl_download,
    input  logic [7:0]      ioctl_index,
    input  logic            ioctl_wr,
    input  logic [24:0]     ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_data,
    output logic [NREG-1:0] mem_we,
    output logic            busy,
    output logic            done,
    output logic [2:0]      last_region,
    output logic [AW:0]     size,
    output logic [AW-1:0]   size_mask,
    output logic [7:0]      checksum,
    output logic            overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_IGNORE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [25:0] CAP = 26'(1) << AW;

    state_t      state;
    logic [2:0]  region;
    logic [AW:0] run_cnt;
    logic [7:0]  run_sum;
    logic        run_ovf;

    // One extra bit so the header subtraction never wraps silently.
    logic [25:0] addr_ext;
    logic [25:0] offset;
    logic        in_hdr;
    logic        in_cap;
    logic [8:0]  idx_ext;
    logic        idx_ok;
    logic [2:0]  region_next;
    logic [AW:0] end_cnt;

    assign addr_ext    = {1'b0, ioctl_addr};
    assign offset      = addr_ext - 26'(HDR_BYTES);
    assign in_hdr      = addr_ext < 26'(HDR_BYTES);
    assign in_cap      = !in_hdr && (offset < CAP);
    assign idx_ext     = {1'b0, ioctl_index};
    assign idx_ok      = (idx_ext >= 9'(IDX_BASE)) && (idx_ext < 9'(IDX_BASE + NREG));
    assign region_next = 3'(idx_ext - 9'(IDX_BASE));
    // Count tracks the highest stored offset + 1, not the number of strobes.
    assign end_cnt     = {1'b0, offset[AW-1:0]} + {{AW{1'b0}}, 1'b1};

    assign busy = (state == S_LOAD) || (state == S_IGNORE);

    // Smallest 2^k-1 covering offsets 0..n-1: smear the top bit of n-1 downward.
    function automatic logic [AW-1:0] mask_of(input logic [AW:0] n);
        logic [AW:0] v;
        v = n - (AW+1)'(1);
        if (n <= (AW+1)'(1)) return '0;
        for (int i = 1; i <= AW; i++) v = v | (v >> i);
        return v[AW-1:0];
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            region      <= '0;
            run_cnt     <= '0;
            run_sum     <= '0;
            run_ovf     <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_we      <= '0;
            done        <= 1'b0;
            last_region <= '0;
            size        <= '0;
            size_mask   <= '0;
            checksum    <= '0;
            overflow    <= 1'b0;
        end else begin
            mem_we <= '0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ioctl_download) begin
                        if (idx_ok) begin
                            state   <= S_LOAD;
                            region  <= region_next;
                            run_cnt <= '0;
                            run_sum <= '0;
                            run_ovf <= 1'b0;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end
                end
                S_LOAD: begin
                    if (!ioctl_download) begin
                        // Status is published on entry to FINISH so that done
                        // and the new values are visible together.
                        state       <= S_FINISH;
                        size        <= run_cnt;
                        size_mask   <= mask_of(run_cnt);
                        checksum    <= run_sum;
                        overflow    <= run_ovf;
                        last_region <= region;
                        done        <= 1'b1;
                    end else if (ioctl_wr && !in_hdr) begin
                        if (in_cap) begin
                            mem_addr <= offset[AW-1:0];
                            mem_data <= ioctl_dout;
                            for (int r = 0; r < NREG; r++)
                                mem_we[r] <= (region == 3'(r));
                            run_sum <= run_sum + ioctl_dout;
                            if (end_cnt > run_cnt) run_cnt <= end_cnt;
                        end else begin
                            run_ovf <= 1'b1;
                        end
                    end
                end
                S_IGNORE: begin
                    if (!ioctl_download) state <= S_IDLE;
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_loader.sv
// Bench for ioctl_loader: randomized downloads against a file-level model of
// what should land in memory and what the status outputs should report.
module tb_ioctl_loader;

    localparam int AW       = 4;
    localparam int NREG     = 2;
    localparam int IDX_BASE = 1;
    localparam int HDR      = 4;
    localparam int CAP      = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            dl;
    logic [7:0]      index;
    logic            wr;
    logic [24:0]     addr;
    logic [7:0]      dout;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_data;
    logic [NREG-1:0] mem_we;
    logic            busy;
    logic            done;
    logic [2:0]      last_region;
    logic [AW:0]     size;
    logic [AW-1:0]   size_mask;
    logic [7:0]      checksum;
    logic            overflow;

    ioctl_loader #(.AW(AW), .NREG(NREG), .IDX_BASE(IDX_BASE), .HDR_BYTES(HDR)) dut (
        .clk_sys(clk), .reset(rst), .ioctl_download(dl), .ioctl_index(index),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .busy(busy),
        .done(done), .last_region(last_region), .size(size), .size_mask(size_mask),
        .checksum(checksum), .overflow(overflow)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0]     cyc;
        logic [NREG-1:0] we;
        logic [AW-1:0]   addr;
        logic [7:0]      data;
    } wr_t;

    wr_t exp_q[$];

    int run_max;      // highest stored file-relative offset, -1 when none
    int run_sum;
    bit run_ovf;
    int cur_region;

    logic [AW:0]   exp_size   = '0;
    logic [AW-1:0] exp_mask   = '0;
    logic [7:0]    exp_sum    = '0;
    logic          exp_ovf    = 1'b0;
    logic [2:0]    exp_region = '0;

    function automatic int mask_model(input int s);
        int p;
        p = 1;
        if (s <= 1) return 0;
        while (p < s) p = p * 2;
        return p - 1;
    endfunction

    // Scoreboard: every cycle either the expected write appears or mem_we is idle.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
                e = exp_q.pop_front();
                total++;
                if (mem_we !== e.we || mem_addr !== e.addr || mem_data !== e.data) begin
                    bad++;
                    $display("FAIL mem_write cyc=%0d got we=%b addr=%0d data=%02h required we=%b addr=%0d data=%02h",
                             cyc, mem_we, mem_addr, mem_data, e.we, e.addr, e.data);
                end
            end else begin
                total++;
                if (mem_we !== '0) begin
                    bad++;
                    $display("FAIL mem_we_idle cyc=%0d got we=%b required 0", cyc, mem_we);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Enter LOAD for ioctl index idx. When chained, download was already
    // raised during the previous FINISH cycle.
    task automatic start_load(input int idx, input bit chained);
        @(posedge clk); #1;
        if (!chained) begin
            dl = 1'b1;
            index = 8'(idx);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_gap got done=%b busy=%b required done=0 busy=0", done, busy);
        end
        @(posedge clk); #1;
        run_max = -1;
        run_sum = 0;
        run_ovf = 1'b0;
        cur_region = idx - IDX_BASE;
    endtask

    // Stream file offsets 0..n-1; sparse randomly skips offsets.
    task automatic send_bytes(input int n, input bit rand_gap, input bit sparse);
        wr_t e;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if (sparse && $urandom_range(0, 3) == 0) continue;
            d = 8'($urandom);
            wr = 1'b1;
            addr = 25'(i);
            dout = d;
            if (i >= HDR) begin
                if (i - HDR < CAP) begin
                    e.cyc  = 32'(cyc + 1);
                    e.we   = NREG'(1) << cur_region;
                    e.addr = AW'(i - HDR);
                    e.data = d;
                    exp_q.push_back(e);
                    if (i - HDR > run_max) run_max = i - HDR;
                    run_sum = (run_sum + int'(d)) & 255;
                end else begin
                    run_ovf = 1'b1;
                end
            end
            @(negedge clk);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_load offset=%0d got %b required 1", i, busy);
            end
            @(posedge clk); #1;
            wr = 1'b0;
            if (rand_gap) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Drop download (optionally with a coinciding strobe that must be lost),
    // then check the FINISH cycle. chain re-raises download inside FINISH.
    task automatic finish_load(input bit fall_wr, input bit chain, input int next_idx);
        dl = 1'b0;
        if (fall_wr) begin
            wr = 1'b1;
            addr = 25'(HDR);
            dout = 8'hA5;
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL pre_finish got busy=%b done=%b required busy=1 done=0", busy, done);
        end
        @(posedge clk); #1;
        wr = 1'b0;
        exp_size   = (AW+1)'(run_max + 1);
        exp_mask   = AW'(mask_model(run_max + 1));
        exp_sum    = 8'(run_sum);
        exp_ovf    = run_ovf;
        exp_region = 3'(cur_region);
        if (chain) begin
            dl = 1'b1;
            index = 8'(next_idx);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL finish_pulse got done=%b busy=%b required done=1 busy=0", done, busy);
        end
        total++;
        if (size !== exp_size || size_mask !== exp_mask) begin
            bad++;
            $display("FAIL size got size=%0d mask=%0d required size=%0d mask=%0d",
                     size, size_mask, exp_size, exp_mask);
        end
        total++;
        if (checksum !== exp_sum || overflow !== exp_ovf || last_region !== exp_region) begin
            bad++;
            $display("FAIL status got sum=%02h ovf=%b region=%0d required sum=%02h ovf=%b region=%0d",
                     checksum, overflow, last_region, exp_sum, exp_ovf, exp_region);
        end
    endtask

    task automatic check_status_held(input string tag);
        total++;
        if (size !== exp_size || size_mask !== exp_mask || checksum !== exp_sum ||
            overflow !== exp_ovf || last_region !== exp_region) begin
            bad++;
            $display("FAIL %s got size=%0d mask=%0d sum=%02h ovf=%b region=%0d required size=%0d mask=%0d sum=%02h ovf=%b region=%0d",
                     tag, size, size_mask, checksum, overflow, last_region,
                     exp_size, exp_mask, exp_sum, exp_ovf, exp_region);
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if (mem_we !== '0 || done !== 1'b0 || busy !== 1'b0 || mem_addr !== '0 || mem_data !== '0) begin
            bad++;
            $display("FAIL %s_port got we=%b done=%b busy=%b addr=%0d data=%02h required all 0",
                     tag, mem_we, done, busy, mem_addr, mem_data);
        end
        total++;
        if (size !== '0 || size_mask !== '0 || checksum !== '0 || overflow !== 1'b0 || last_region !== '0) begin
            bad++;
            $display("FAIL %s_status got size=%0d mask=%0d sum=%02h ovf=%b region=%0d required all 0",
                     tag, size, size_mask, checksum, overflow, last_region);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; dl = 1'b0; index = '0; wr = 1'b0; addr = '0; dout = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_load(1, 1'b0);
        send_bytes(HDR + 3, 1'b0, 1'b0);
        finish_load(1'b0, 1'b0, 0);
    endtask

    task automatic test_header();
        start_load(2, 1'b0);
        send_bytes(HDR + 4, 1'b1, 1'b0);
        finish_load(1'b0, 1'b0, 0);
    endtask

    task automatic test_overflow();
        start_load(1, 1'b0);
        send_bytes(HDR + CAP + 4, 1'b0, 1'b0);
        finish_load(1'b0, 1'b0, 0);
    endtask

    task automatic run_ignore(input int idx, input int ncyc);
        @(posedge clk); #1;
        dl = 1'b1;
        index = 8'(idx);
        @(negedge clk);
        repeat (ncyc) begin
            @(posedge clk); #1;
            wr = 1'($urandom_range(0, 1));
            addr = 25'($urandom_range(0, HDR + CAP - 1));
            dout = 8'($urandom);
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL ignore_busy idx=%0d got busy=%b done=%b required busy=1 done=0", idx, busy, done);
            end
        end
        @(posedge clk); #1;
        wr = 1'b0;
        dl = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_exit idx=%0d got busy=%b done=%b required busy=0 done=0", idx, busy, done);
        end
        check_status_held("ignore_status");
    endtask

    task automatic test_ignore();
        run_ignore(7, 6);
        run_ignore(0, 3);
    endtask

    task automatic test_fall_wr();
        start_load(2, 1'b0);
        send_bytes(HDR + 5, 1'b1, 1'b0);
        finish_load(1'b1, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        start_load(2, 1'b0);
        send_bytes(5, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        exp_size = '0; exp_mask = '0; exp_sum = '0; exp_ovf = 1'b0; exp_region = '0;
        @(negedge clk);
        check_all_zero("reset_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        // Download still high: the next edge starts a fresh load.
        @(posedge clk); #1;
        run_max = -1;
        run_sum = 0;
        run_ovf = 1'b0;
        cur_region = 1;
        send_bytes(10, 1'b0, 1'b0);
        finish_load(1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        start_load(1, 1'b0);
        send_bytes(HDR + 6, 1'b1, 1'b0);
        finish_load(1'b0, 1'b1, 2);
        start_load(2, 1'b1);
        send_bytes(HDR + 9, 1'b1, 1'b0);
        finish_load(1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        bit chained;
        bit nxt;
        int idx;
        int nidx;
        chained = 1'b0;
        idx = 1;
        for (int k = 0; k < 8; k++) begin
            if (!chained) idx = $urandom_range(IDX_BASE, IDX_BASE + NREG - 1);
            start_load(idx, chained);
            send_bytes($urandom_range(0, HDR + CAP + 3), 1'b1, 1'($urandom_range(0, 1)));
            nxt = 1'($urandom_range(0, 1)) && (k < 7);
            nidx = $urandom_range(IDX_BASE, IDX_BASE + NREG - 1);
            finish_load(1'($urandom_range(0, 1)), nxt, nidx);
            chained = nxt;
            idx = nidx;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_header();
        test_overflow();
        test_ignore();
        test_fall_wr();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_writes got %0d outstanding required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Parameters
REQ-001 AW, 15, target memory address width in bytes (region capacity 2^AW).
REQ-002 NREG, 2, number of load regions, range 1..8.
REQ-003 IDX_BASE, 1, ioctl_index value of region 0; region r is selected by index IDX_BASE+r.
REQ-004 HDR_BYTES, 0, number of leading file bytes discarded (header skip), range 0..4096.

Interface
REQ-005 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ioctl_download  in  1  download window from hps_io, level.
REQ-008 ioctl_index  in  8  file slot index of the current download.
REQ-009 ioctl_wr  in  1  one-cycle byte strobe.
REQ-010 ioctl_addr  in  25  file byte offset of ioctl_dout.
REQ-011 ioctl_dout  in  8  file data byte.
REQ-012 mem_addr  out  AW  registered target byte address.
REQ-013 mem_data  out  8  registered target data.
REQ-014 mem_we  out  NREG  one-hot write enable; bit r writes region r.
REQ-015 busy  out  1  high while state is LOAD or IGNORE (system holds CPU in reset).
REQ-016 done  out  1  one-cycle pulse at end of a valid-region load.
REQ-017 last_region  out  3  region number of the most recent completed load.
REQ-018 size  out  AW+1  bytes stored by the most recent completed load.
REQ-019 size_mask  out  AW  mirror mask: smallest 2^k-1 with 2^k >= size (0 when size<=1).
REQ-020 checksum  out  8  mod-256 sum of bytes stored by the most recent completed load.
REQ-021 overflow  out  1  set if the most recent load had a byte at offset >= HDR_BYTES+2^AW.

Function
REQ-022 FSM states: IDLE, LOAD, IGNORE, FINISH.
REQ-023 IDLE: ioctl_download=1 and IDX_BASE <= ioctl_index < IDX_BASE+NREG -> LOAD, latch region=index-IDX_BASE, clear running count/sum/overflow.
REQ-024 IDLE: ioctl_download=1 with index out of range -> IGNORE; no mem_we, status outputs unchanged.
REQ-025 IGNORE: ioctl_download=0 -> IDLE; no done pulse.
REQ-026 LOAD: ioctl_wr accepted only when ioctl_download=1 in the same cycle; writes in IDLE/IGNORE/FINISH are dropped.
REQ-027 Accepted byte with ioctl_addr < HDR_BYTES: discarded, no mem_we.
REQ-028 Accepted byte with HDR_BYTES <= ioctl_addr < HDR_BYTES+2^AW: next cycle mem_we[region]=1 for exactly one cycle, mem_addr=ioctl_addr-HDR_BYTES (low AW bits), mem_data=ioctl_dout; latency 1 cycle.
REQ-029 Accepted byte beyond capacity: no mem_we, running overflow flag set.
REQ-030 Running count = max stored offset+1 (not number of strobes); running sum adds each stored byte, wraps mod 256.
REQ-031 LOAD: ioctl_download=0 -> FINISH; an ioctl_wr in the same cycle as the falling download is dropped.
REQ-032 FINISH (one cycle): copy running count/sum/overflow/region to size/checksum/overflow/last_region, compute size_mask, done=1; -> IDLE next cycle.
REQ-033 Status outputs hold between loads; size/checksum/size_mask are updated only in FINISH.
REQ-034 Download reasserted immediately after FINISH is handled from IDLE in the following cycle; no loads merge.
REQ-035 busy is combinational from state, no extra latency.

Reset
REQ-036 Reset asserted at any time -> state IDLE, mem_we=0, done=0, busy=0, mem_addr=0, mem_data=0, size=0, size_mask=0, checksum=0, overflow=0, last_region=0, running counters 0.
REQ-037 Reset mid-LOAD aborts without done; memory contents become undefined; if ioctl_download is still high after release, a new LOAD starts with cleared counters.

Verification
REQ-038 AW=15, HDR=0, index 1, bytes 0x01,0x02,0x03 at offsets 0..2 -> three mem_we[0] pulses, addr 0,1,2, each 1 cycle after ioctl_wr; done once; size=3, size_mask=3, checksum=0x06, overflow=0, busy high throughout.
REQ-039 HDR_BYTES=16, index 2, 20-byte file -> first 16 bytes produce no mem_we; bytes 16..19 land at addr 0..3 on mem_we[1]; size=4, last_region=1.
REQ-040 AW=4, 20-byte file -> 16 writes, offsets 16..19 dropped, overflow=1, size=16, size_mask=15.
REQ-041 Index 7 with NREG=2 -> no mem_we, busy high during download, no done, previous size/checksum unchanged.
REQ-042 Reset pulse after 5 of 10 bytes -> all outputs 0 next edge, no done; reload of 10 bytes gives size=10, size_mask=15.
REQ-043 ioctl_wr coincident with falling ioctl_download -> byte not written, not counted; done follows one cycle later.
